// File: rtl/vec_execute_unit_if.sv
// Decode-to-execute and execute-to-writeback signal bundle for vec_execute_unit.
// The slave modport is the execute unit's view; master is the upstream/downstream side.
interface vec_execute_unit_if #(
    parameter int NUM_LANES     = 4,
    parameter int LANE_WIDTH    = 16,
    parameter int VREG_ID_WIDTH = 6
);
    localparam int IDX_WIDTH = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int VEC_WIDTH = NUM_LANES * LANE_WIDTH;

    logic                     I_Valid;
    logic                     O_Ready;
    logic [2:0]               I_Op;
    logic [VEC_WIDTH-1:0]     I_Src1Vec;
    logic [VEC_WIDTH-1:0]     I_Src2Vec;
    logic [LANE_WIDTH-1:0]    I_Imm;
    logic [IDX_WIDTH-1:0]     I_Idx;
    logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx;
    logic                     I_Stall;
    logic                     O_Valid;
    logic [VEC_WIDTH-1:0]     O_VecDestValue;
    logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx;
    logic                     O_VRegWEn;
    logic [NUM_LANES-1:0]     O_ZeroMask;
    logic                     O_Busy;

    modport master (
        output I_Valid, I_Op, I_Src1Vec, I_Src2Vec, I_Imm, I_Idx, I_DestVRegIdx, I_Stall,
        input  O_Ready, O_Valid, O_VecDestValue, O_DestVRegIdx, O_VRegWEn, O_ZeroMask, O_Busy
    );

    modport slave (
        input  I_Valid, I_Op, I_Src1Vec, I_Src2Vec, I_Imm, I_Idx, I_DestVRegIdx, I_Stall,
        output O_Ready, O_Valid, O_VecDestValue, O_DestVRegIdx, O_VRegWEn, O_ZeroMask, O_Busy
    );
endinterface

// File: rtl/vec_execute_unit.sv
// SIMD vector execute stage: single-cycle lane ALU ops, multi-cycle lane multiply,
// valid/ready acceptance and a single registered output slot held under downstream stall.
module vec_execute_unit #(
    parameter int NUM_LANES     = 4,
    parameter int LANE_WIDTH    = 16,
    parameter int VREG_ID_WIDTH = 6,
    parameter int MUL_CYCLES    = 3
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET_N,
    vec_execute_unit_if.slave bus
);
    localparam int VEC_WIDTH = NUM_LANES * LANE_WIDTH;
    localparam int CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] OP_VADD     = 3'd0;
    localparam logic [2:0] OP_VSUB     = 3'd1;
    localparam logic [2:0] OP_VAND     = 3'd2;
    localparam logic [2:0] OP_VMOV     = 3'd3;
    localparam logic [2:0] OP_VMOVI    = 3'd4;
    localparam logic [2:0] OP_VCOMPMOV = 3'd5;
    localparam logic [2:0] OP_VMUL     = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]               state_q,    state_d;
    logic [CNT_W-1:0]         cnt_q,      cnt_d;
    logic [VEC_WIDTH-1:0]     mul_a_q,    mul_a_d;
    logic [VEC_WIDTH-1:0]     mul_b_q,    mul_b_d;
    logic [VREG_ID_WIDTH-1:0] mul_dest_q, mul_dest_d;
    logic                     valid_q,    valid_d;
    logic [VEC_WIDTH-1:0]     vec_q,      vec_d;
    logic [VREG_ID_WIDTH-1:0] dest_q,     dest_d;
    logic                     wen_q,      wen_d;
    logic [NUM_LANES-1:0]     zmask_q,    zmask_d;

    logic                     ready;
    logic                     accept;
    logic                     slot_blocked;
    logic                     mul_done;
    logic [VEC_WIDTH-1:0]     alu_vec;
    logic [VEC_WIDTH-1:0]     mul_vec;
    logic [VEC_WIDTH-1:0]     load_vec;

    assign slot_blocked = valid_q && bus.I_Stall;
    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign ready    = I_RESET_N && (state_q == ST_IDLE) && !slot_blocked;
    assign accept   = bus.I_Valid && ready;
    assign mul_done = (state_q == ST_MUL) && (cnt_q == '0) && !slot_blocked;

    always_comb begin
        alu_vec = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            logic [LANE_WIDTH-1:0] a;
            logic [LANE_WIDTH-1:0] b;
            logic [LANE_WIDTH-1:0] r;
            a = bus.I_Src1Vec[k*LANE_WIDTH +: LANE_WIDTH];
            b = bus.I_Src2Vec[k*LANE_WIDTH +: LANE_WIDTH];
            r = '0;
            case (bus.I_Op)
                OP_VADD:     r = a + b;
                OP_VSUB:     r = a - b;
                OP_VAND:     r = a & b;
                OP_VMOV:     r = a;
                OP_VMOVI:    r = bus.I_Imm;
                OP_VCOMPMOV: r = (k == 32'(bus.I_Idx)) ? bus.I_Imm : a;
                default:     r = '0;
            endcase
            alu_vec[k*LANE_WIDTH +: LANE_WIDTH] = r;
        end
    end

    // Lane products are taken from the latched operands; only the low LANE_WIDTH bits are kept.
    always_comb begin
        mul_vec = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            logic [LANE_WIDTH-1:0] p;
            p = mul_a_q[k*LANE_WIDTH +: LANE_WIDTH] * mul_b_q[k*LANE_WIDTH +: LANE_WIDTH];
            mul_vec[k*LANE_WIDTH +: LANE_WIDTH] = p;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_dest_d = mul_dest_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (bus.I_Op == OP_VMUL)) begin
                    state_d    = ST_MUL;
                    cnt_d      = CNT_W'(MUL_CYCLES - 1);
                    mul_a_d    = bus.I_Src1Vec;
                    mul_b_d    = bus.I_Src2Vec;
                    mul_dest_d = bus.I_DestVRegIdx;
                end
            end
            ST_MUL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (mul_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A new result always wins over draining, so a drain and load in one cycle keeps O_Valid high.
    always_comb begin
        valid_d  = valid_q;
        vec_d    = vec_q;
        dest_d   = dest_q;
        wen_d    = wen_q;
        zmask_d  = zmask_q;
        load_vec = '0;
        if (accept && (bus.I_Op != OP_VMUL)) begin
            load_vec = alu_vec;
            valid_d  = 1'b1;
            vec_d    = alu_vec;
            dest_d   = bus.I_DestVRegIdx;
            wen_d    = (bus.I_Op != OP_RSVD);
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                zmask_d[k] = (load_vec[k*LANE_WIDTH +: LANE_WIDTH] == '0);
            end
        end else if (mul_done) begin
            load_vec = mul_vec;
            valid_d  = 1'b1;
            vec_d    = mul_vec;
            dest_d   = mul_dest_q;
            wen_d    = 1'b1;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                zmask_d[k] = (load_vec[k*LANE_WIDTH +: LANE_WIDTH] == '0);
            end
        end else if (valid_q && !bus.I_Stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_dest_q <= '0;
            valid_q    <= 1'b0;
            vec_q      <= '0;
            dest_q     <= '0;
            wen_q      <= 1'b0;
            zmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_dest_q <= mul_dest_d;
            valid_q    <= valid_d;
            vec_q      <= vec_d;
            dest_q     <= dest_d;
            wen_q      <= wen_d;
            zmask_q    <= zmask_d;
        end
    end

    assign bus.O_Ready        = ready;
    assign bus.O_Valid        = valid_q;
    assign bus.O_VecDestValue = vec_q;
    assign bus.O_DestVRegIdx  = dest_q;
    assign bus.O_VRegWEn      = wen_q;
    assign bus.O_ZeroMask     = zmask_q;
    assign bus.O_Busy         = (state_q == ST_MUL);
endmodule

// File: doc/vec_execute_unit.md
Name: vec_execute_unit

Overview:
Parametrised SIMD execute stage for the GPU pipeline. It sits between decode and the vector writeback/memory stage and handles all vector ALU opcodes across NUM_LANES independent lanes. It adds a multi-cycle lane multiply, a valid/ready input handshake and downstream stall holding. Results leave through a single registered output slot.

Parameters:
NUM_LANES, 4, number of SIMD lanes (legal 1..16)
LANE_WIDTH, 16, bits per lane
VREG_ID_WIDTH, 6, destination vector register index width
MUL_CYCLES, 3, VMUL latency in cycles from acceptance to O_Valid (legal 2..16)

Ports:
I_CLOCK  in  1  clock; all state updates on posedge
I_RESET_N  in  1  asynchronous active-low reset
I_Valid  in  1  decode presents an operation
O_Ready  out  1  unit accepts the operation this cycle
I_Op  in  3  0 VADD, 1 VSUB, 2 VAND, 3 VMOV, 4 VMOVI, 5 VCOMPMOV, 6 VMUL, 7 reserved
I_Src1Vec  in  NUM_LANES*LANE_WIDTH  source vector 1; lane k is bits [k*LANE_WIDTH +: LANE_WIDTH]
I_Src2Vec  in  NUM_LANES*LANE_WIDTH  source vector 2
I_Imm  in  LANE_WIDTH  immediate
I_Idx  in  max(1,clog2(NUM_LANES))  lane index for VCOMPMOV
I_DestVRegIdx  in  VREG_ID_WIDTH  destination vector register
I_Stall  in  1  downstream cannot take the output this cycle
O_Valid  out  1  output slot holds a result
O_VecDestValue  out  NUM_LANES*LANE_WIDTH  result vector
O_DestVRegIdx  out  VREG_ID_WIDTH  destination register of the result
O_VRegWEn  out  1  result must be written to the vector register file
O_ZeroMask  out  NUM_LANES  bit k = 1 when result lane k == 0
O_Busy  out  1  VMUL in flight

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all outputs 0, state IDLE, multiply counter 0.
  - Reset during MUL aborts the operation; no result is produced after release.
- States:
  - IDLE: no multiply pending.
  - MUL: multiply in flight; counter counts down from MUL_CYCLES-1.
- Ready and accept:
  - O_Ready = (state==IDLE) && !(O_Valid && I_Stall). O_Ready is combinational.
  - An operation is accepted when I_Valid && O_Ready. The unit never drops an accepted op.
- Output slot:
  - O_Valid clears on a cycle where O_Valid && !I_Stall and no new result is loaded.
  - Slot contents are frozen while O_Valid && I_Stall.
- Single-cycle ops (0–5, 7):
  - Operands are captured at accept. The result is loaded into the slot on the same edge, so O_Valid=1 the next cycle.
  - Back-to-back accepts are allowed with 1 result per cycle when I_Stall=0.
- Per-lane arithmetic: modulo 2^LANE_WIDTH, wrap-around, no saturation, no cross-lane carry.
  - VADD: a+b. VSUB: a-b. VAND: a&b.
  - VMOV: Src1 copied.
  - VMOVI: I_Imm broadcast to all lanes.
  - VCOMPMOV: Src1 copied, except lane I_Idx = I_Imm. If I_Idx >= NUM_LANES, no lane is replaced.
  - VMUL: low LANE_WIDTH bits of the unsigned a*b.
  - Op 7: result all-zero and O_VRegWEn=0. O_Valid still pulses.
- O_VRegWEn = 1 for ops 0–6.
- O_ZeroMask is registered with the result.
- VMUL:
  - On accept, go IDLE→MUL, O_Busy=1, O_Ready=0. Operands are latched.
  - Counter decrements each cycle. When it reaches 0, the result loads into the slot and the state returns to IDLE. O_Valid=1 exactly MUL_CYCLES cycles after the accept edge.
  - If the slot is still occupied and stalled at completion, the unit stays in MUL (counter 0) until the slot frees. The result loads on the edge where !I_Stall.
- Simultaneous drain and load: when the slot drains and a new op is accepted in the same cycle, the new result replaces the old one and O_Valid stays 1.

Test Plan:
- Reset release, then NUM_LANES=4, LANE_WIDTH=16, VADD Src1 lanes {1,2,3,0xFFFF} + Src2 {1,1,1,1} → next cycle O_VecDestValue lanes {2,3,4,0}, O_ZeroMask=4'b1000, O_VRegWEn=1.
- VCOMPMOV Src1 {5,5,5,5}, Idx=2, Imm=9 → lanes {5,5,9,5}; then VMOVI Imm=0 → O_ZeroMask=4'b1111.
- VMUL MUL_CYCLES=3, lanes {300,2,0,7}×{300,3,5,7} → O_Busy high 3 cycles, O_Ready=0, O_Valid at cycle 3 with lanes {0x5F90,6,0,49}.
- Hold I_Stall=1 for 4 cycles after a VSUB {0}-{1} result → output frozen at 0xFFFF per lane, O_Ready=0; drop stall → O_Valid clears next cycle.
- Stream 8 VADD ops with I_Valid=1, I_Stall=0 → 8 consecutive O_Valid cycles, no bubbles, in-order destinations.
- Assert I_RESET_N=0 mid-VMUL (cycle 1) → outputs 0 immediately; after release O_Valid stays 0 and O_Ready=1.
